ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the five-stage pipeline. It sits directly downstream of the decode stage and consumes that stage's registered outputs: immediate, two register values, write-back destination and opcode. It computes ALU results, memory addresses and branch decisions in one cycle. `MUL` runs as an iterative 32-step shift-add, and the stage holds the upstream pipeline with `stall_out` while it does so. All results are registered into the EX/MEM boundary.

## Interface
Parameters:
- `WIDTH`, default 32: datapath width.
- `MUL_STEPS`, default 32: shift-add iterations per `MUL`; must equal `WIDTH`.

Ports:
- `clk`  in  1  pipeline clock; one clock domain; everything updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imm_in`  in  32  sign-extended immediate from decode.
- `val_rs_in`  in  32  first register operand.
- `val_rt_in`  in  32  second register operand.
- `rwd_in`  in  5  write-back register; 0 means no write.
- `opcode_in`  in  6  opcode, encoded with the `def.v` macros.
- `valid_in`  in  1  decode outputs hold a real instruction.
- `stall_out`  out  1  combinational; upstream holds all of its outputs while this is high.
- `alu_res_out`  out  32  result or memory address.
- `val_rt_out`  out  32  `val_rt_in` passed through, used as store data.
- `rwd_out`  out  5  destination passed through.
- `opcode_out`  out  6  opcode passed through.
- `branch_taken_out`  out  1  set for a `BEQ` whose operands are equal.
- `valid_out`  out  1  EX/MEM register holds a real instruction.

## Operation
- Operations, all 32-bit and wrapping, with no overflow flag:
  - `ADD`: rs+rt.
  - `SUB`: rs−rt.
  - `AND`: rs&rt.
  - `OR`: rs|rt.
  - `LDW`/`SDW`: rs+imm.
  - `BEQ`: result rs−rt; `branch_taken_out` = (rs==rt).
  - `JUMP`: result = imm.
  - `MUL`: low 32 bits of rs×rt, which are identical for signed and unsigned operands.
- Any opcode not listed executes as a NOP: `valid_out`=1, `alu_res_out`=0, `rwd_out`=0.
- `branch_taken_out` is 0 for every opcode except `BEQ`.
- FSM states:
  - IDLE:
    - `valid_in`=1 and the opcode is not `MUL`: register the result, `valid_out`<=1.
    - `valid_in`=0: insert a bubble. `valid_out`, `rwd_out`, `opcode_out` and `branch_taken_out` go to 0; `alu_res_out` and `val_rt_out` also go to 0.
    - `valid_in`=1 with `MUL`: latch the multiplicand, multiplier, `rwd_in`, `opcode_in` and `val_rt_in`; clear the accumulator; `cnt`<=0; `valid_out`<=0; go to BUSY.
  - BUSY, one step per edge:
    - If multiplier bit 0 is set, the accumulator adds the multiplicand.
    - Multiplicand shifts left 1; multiplier shifts right 1; `cnt`++.
    - On the edge where `cnt`==`MUL_STEPS`−1: load the accumulator's final value into `alu_res_out`, restore the latched fields, set `valid_out`<=1, return to IDLE.
    - Until then `valid_out`=0 on every BUSY edge.
    - `valid_in` and the data inputs are ignored in BUSY.
- `stall_out` = (IDLE & `valid_in` & opcode==`MUL`) | (BUSY & `cnt`≠`MUL_STEPS`−1).

## Timing
- Reset: state IDLE, `cnt`=0, accumulator 0, every output 0, `stall_out`=0 in the following cycle.
- Reset mid-multiply: the `MUL` is abandoned, no result is produced, and the upstream holding register is released.
- Non-`MUL` latency: 1 cycle. An instruction present before edge E appears on the outputs after E.
- `MUL` accepted at edge E0:
  - BUSY from E1 through E32.
  - The result and `valid_out`=1 appear after E32.
- `stall_out` during a `MUL`:
  - High in the cycle before E0 and in the cycles before E1 through E31: 32 cycles in total.
  - Low in the cycle before E32, so upstream advances at E32 at the same time the result is written.
  - This prevents the held `MUL` from being re-issued.
- Back-to-back `MUL`s:
  - The second `MUL` is seen in IDLE in the cycle after E32; `stall_out` rises again.
  - Throughput is one `MUL` per 33 cycles.
- A bubble (`valid_in`=0) presented while `stall_out` is low is a bubble on the output after one cycle.

## Test plan
- Reset: assert `rst` for 2 cycles with random inputs -> every output 0 and `stall_out` 0 on the cycle after release.
- `ADD` rs=0xFFFFFFFF, rt=0x2, rwd=5 -> next cycle `alu_res_out`=0x00000001, `rwd_out`=5, `valid_out`=1.
- `LDW` rs=0x100, imm=0xFFFFFFFC; then `BEQ` rs=rt=0x55 -> address 0xFC; then `branch_taken_out`=1 with `alu_res_out`=0; then `BEQ` rs=1, rt=2 gives `branch_taken_out`=0.
- `MUL` rs=7, rt=0xFFFFFFFD held under stall, followed by `ADD` 1+1:
  - `stall_out` is high for exactly 32 cycles.
  - After E32: `alu_res_out`=0xFFFFFFEB, `valid_out`=1.
  - The `ADD` result 0x2 follows one cycle later.
- `MUL` 0xFFFF×0xFFFF with `rst` asserted at `cnt`=10 -> all outputs 0, `stall_out` 0, no MUL result ever appears; a following `OR` 0xF0|0x0F returns 0xFF.
- Alternate `valid_in` 0/1 with `SUB` 5−7 -> bubble cycles show `valid_out`=0 and `rwd_out`=0; valid cycles give 0xFFFFFFFE.

Source files
------------

// File: rtl/ex_stage_if.sv
// Decode-to-execute bus: decode operands in, EX/MEM register and stall back out.
// The master side is the decode stage, the slave side is ex_stage.
interface ex_stage_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] imm_in;
   logic [WIDTH-1:0] val_rs_in;
   logic [WIDTH-1:0] val_rt_in;
   logic [4:0]       rwd_in;
   logic [5:0]       opcode_in;
   logic             valid_in;
   logic             stall_out;
   logic [WIDTH-1:0] alu_res_out;
   logic [WIDTH-1:0] val_rt_out;
   logic [4:0]       rwd_out;
   logic [5:0]       opcode_out;
   logic             branch_taken_out;
   logic             valid_out;

   modport master (
      output imm_in, val_rs_in, val_rt_in, rwd_in, opcode_in, valid_in,
      input  stall_out, alu_res_out, val_rt_out, rwd_out, opcode_out,
             branch_taken_out, valid_out
   );

   modport slave (
      input  imm_in, val_rs_in, val_rt_in, rwd_in, opcode_in, valid_in,
      output stall_out, alu_res_out, val_rt_out, rwd_out, opcode_out,
             branch_taken_out, valid_out
   );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU/address/branch plus an iterative shift-add MUL,
// all results registered into the EX/MEM boundary.
module ex_stage #(
   parameter int WIDTH     = 32,
   parameter int MUL_STEPS = 32
) (
   input logic     clk,
   input logic     rst,
   ex_stage_if.slave bus
);
   localparam logic [5:0] OP_ADD  = 6'd1;
   localparam logic [5:0] OP_SUB  = 6'd2;
   localparam logic [5:0] OP_AND  = 6'd3;
   localparam logic [5:0] OP_OR   = 6'd4;
   localparam logic [5:0] OP_LDW  = 6'd5;
   localparam logic [5:0] OP_SDW  = 6'd6;
   localparam logic [5:0] OP_BEQ  = 6'd7;
   localparam logic [5:0] OP_JUMP = 6'd8;
   localparam logic [5:0] OP_MUL  = 6'd9;

   localparam int            CW   = $clog2(MUL_STEPS) + 1;
   localparam logic [CW-1:0] LAST = CW'(MUL_STEPS - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t           state_r;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] acc_r;
   logic [WIDTH-1:0] mcand_r;
   logic [WIDTH-1:0] mplier_r;
   logic [WIDTH-1:0] rt_r;
   logic [4:0]       rwd_r;
   logic [5:0]       op_r;

   logic [WIDTH-1:0] alu_s;
   logic [WIDTH-1:0] acc_next_s;
   logic             br_s;
   logic             nop_s;
   logic             mul_req_s;

   assign mul_req_s  = bus.valid_in && (bus.opcode_in == OP_MUL);
   assign acc_next_s = mplier_r[0] ? (acc_r + mcand_r) : acc_r;

   // Released one edge early so upstream advances on the same edge the product lands.
   assign bus.stall_out = ((state_r == IDLE) && mul_req_s) ||
                          ((state_r == BUSY) && (cnt_r != LAST));

   // Single-cycle result for every opcode except MUL.
   always_comb begin
      alu_s = '0;
      br_s  = 1'b0;
      nop_s = 1'b0;
      case (bus.opcode_in)
         OP_ADD:  alu_s = bus.val_rs_in + bus.val_rt_in;
         OP_SUB:  alu_s = bus.val_rs_in - bus.val_rt_in;
         OP_AND:  alu_s = bus.val_rs_in & bus.val_rt_in;
         OP_OR:   alu_s = bus.val_rs_in | bus.val_rt_in;
         OP_LDW:  alu_s = bus.val_rs_in + bus.imm_in;
         OP_SDW:  alu_s = bus.val_rs_in + bus.imm_in;
         OP_BEQ: begin
            alu_s = bus.val_rs_in - bus.val_rt_in;
            br_s  = (bus.val_rs_in == bus.val_rt_in);
         end
         OP_JUMP: alu_s = bus.imm_in;
         OP_MUL:  alu_s = '0;
         default: nop_s = 1'b1;
      endcase
   end

   // Control FSM, multiplier datapath and the EX/MEM output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r              <= IDLE;
         cnt_r                <= '0;
         acc_r                <= '0;
         mcand_r              <= '0;
         mplier_r             <= '0;
         rt_r                 <= '0;
         rwd_r                <= 5'd0;
         op_r                 <= 6'd0;
         bus.alu_res_out      <= '0;
         bus.val_rt_out       <= '0;
         bus.rwd_out          <= 5'd0;
         bus.opcode_out       <= 6'd0;
         bus.branch_taken_out <= 1'b0;
         bus.valid_out        <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (mul_req_s) begin
                  mcand_r              <= bus.val_rs_in;
                  mplier_r             <= bus.val_rt_in;
                  rt_r                 <= bus.val_rt_in;
                  rwd_r                <= bus.rwd_in;
                  op_r                 <= bus.opcode_in;
                  acc_r                <= '0;
                  cnt_r                <= '0;
                  bus.alu_res_out      <= '0;
                  bus.val_rt_out       <= '0;
                  bus.rwd_out          <= 5'd0;
                  bus.opcode_out       <= 6'd0;
                  bus.branch_taken_out <= 1'b0;
                  bus.valid_out        <= 1'b0;
                  state_r              <= BUSY;
               end else if (bus.valid_in) begin
                  bus.alu_res_out      <= alu_s;
                  bus.val_rt_out       <= bus.val_rt_in;
                  bus.rwd_out          <= nop_s ? 5'd0 : bus.rwd_in;
                  bus.opcode_out       <= bus.opcode_in;
                  bus.branch_taken_out <= br_s;
                  bus.valid_out        <= 1'b1;
               end else begin
                  bus.alu_res_out      <= '0;
                  bus.val_rt_out       <= '0;
                  bus.rwd_out          <= 5'd0;
                  bus.opcode_out       <= 6'd0;
                  bus.branch_taken_out <= 1'b0;
                  bus.valid_out        <= 1'b0;
               end
            end
            BUSY: begin
               acc_r    <= acc_next_s;
               mcand_r  <= mcand_r << 1;
               mplier_r <= mplier_r >> 1;
               cnt_r    <= cnt_r + CW'(1);
               if (cnt_r == LAST) begin
                  bus.alu_res_out      <= acc_next_s;
                  bus.val_rt_out       <= rt_r;
                  bus.rwd_out          <= rwd_r;
                  bus.opcode_out       <= op_r;
                  bus.branch_taken_out <= 1'b0;
                  bus.valid_out        <= 1'b1;
                  state_r              <= IDLE;
               end else begin
                  bus.valid_out <= 1'b0;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: cycle-level behavioural model plus literal spot checks.
module tb_ex_stage;
   localparam logic [5:0] OP_ADD  = 6'd1;
   localparam logic [5:0] OP_SUB  = 6'd2;
   localparam logic [5:0] OP_AND  = 6'd3;
   localparam logic [5:0] OP_OR   = 6'd4;
   localparam logic [5:0] OP_LDW  = 6'd5;
   localparam logic [5:0] OP_SDW  = 6'd6;
   localparam logic [5:0] OP_BEQ  = 6'd7;
   localparam logic [5:0] OP_JUMP = 6'd8;
   localparam logic [5:0] OP_MUL  = 6'd9;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   ex_stage_if bus ();
   ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a MUL occupies 32 edges after acceptance, then the product appears.
   int          mul_left = 0;
   bit          model_ok = 1'b0;
   logic [31:0] m_a, m_b, m_rt;
   logic [4:0]  m_rwd;
   logic [5:0]  m_op;
   logic [31:0] e_alu, e_rt;
   logic [4:0]  e_rwd;
   logic [5:0]  e_op;
   logic        e_br, e_valid;

   always @(posedge clk) begin
      if (rst) begin
         mul_left <= 0; model_ok <= 1'b1;
         e_alu <= 32'd0; e_rt <= 32'd0; e_rwd <= 5'd0; e_op <= 6'd0; e_br <= 1'b0; e_valid <= 1'b0;
      end else if (mul_left > 0) begin
         mul_left <= mul_left - 1;
         if (mul_left == 1) begin
            e_alu <= m_a * m_b; e_rt <= m_rt; e_rwd <= m_rwd; e_op <= m_op; e_br <= 1'b0; e_valid <= 1'b1;
         end else begin
            e_valid <= 1'b0;
         end
      end else if (bus.valid_in && bus.opcode_in == OP_MUL) begin
         mul_left <= 32;
         m_a <= bus.val_rs_in; m_b <= bus.val_rt_in; m_rt <= bus.val_rt_in;
         m_rwd <= bus.rwd_in; m_op <= bus.opcode_in;
         e_alu <= 32'd0; e_rt <= 32'd0; e_rwd <= 5'd0; e_op <= 6'd0; e_br <= 1'b0; e_valid <= 1'b0;
      end else if (bus.valid_in) begin
         e_valid <= 1'b1; e_op <= bus.opcode_in; e_rt <= bus.val_rt_in; e_rwd <= bus.rwd_in; e_br <= 1'b0;
         case (bus.opcode_in)
            OP_ADD:  e_alu <= bus.val_rs_in + bus.val_rt_in;
            OP_SUB:  e_alu <= bus.val_rs_in - bus.val_rt_in;
            OP_AND:  e_alu <= bus.val_rs_in & bus.val_rt_in;
            OP_OR:   e_alu <= bus.val_rs_in | bus.val_rt_in;
            OP_LDW, OP_SDW: e_alu <= bus.val_rs_in + bus.imm_in;
            OP_BEQ: begin
               e_alu <= bus.val_rs_in - bus.val_rt_in;
               e_br  <= (bus.val_rs_in == bus.val_rt_in);
            end
            OP_JUMP: e_alu <= bus.imm_in;
            default: begin e_alu <= 32'd0; e_rwd <= 5'd0; end
         endcase
      end else begin
         e_alu <= 32'd0; e_rt <= 32'd0; e_rwd <= 5'd0; e_op <= 6'd0; e_br <= 1'b0; e_valid <= 1'b0;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      logic exp_stall;
      if (model_ok) begin
         exp_stall = (mul_left == 0 && bus.valid_in === 1'b1 && bus.opcode_in == OP_MUL) || (mul_left > 1);
         chk("m_valid", {31'd0, bus.valid_out}, {31'd0, e_valid});
         chk("m_alu", bus.alu_res_out, e_alu);
         chk("m_rt", bus.val_rt_out, e_rt);
         chk("m_rwd", {27'd0, bus.rwd_out}, {27'd0, e_rwd});
         chk("m_op", {26'd0, bus.opcode_out}, {26'd0, e_op});
         chk("m_br", {31'd0, bus.branch_taken_out}, {31'd0, e_br});
         chk("m_stall", {31'd0, bus.stall_out}, {31'd0, exp_stall});
      end
   end

   // Present one instruction, hold it while stalled, return just after the consuming edge.
   task automatic issue(input logic v, input logic [5:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] imm, input logic [4:0] rd,
                        output int stalls);
      int n;
      bus.valid_in = v; bus.opcode_in = op; bus.val_rs_in = rs;
      bus.val_rt_in = rt; bus.imm_in = imm; bus.rwd_in = rd;
      stalls = 0; n = 0;
      @(negedge clk);
      while (bus.stall_out === 1'b1 && n < 40) begin
         stalls++; n++;
         @(negedge clk);
      end
      chk("stall_bound", {31'd0, (n < 40)}, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic expect_out(input string name, input logic [31:0] alu, input logic [4:0] rd,
                             input logic v, input logic br);
      chk({name, "_alu"}, bus.alu_res_out, alu);
      chk({name, "_rwd"}, {27'd0, bus.rwd_out}, {27'd0, rd});
      chk({name, "_valid"}, {31'd0, bus.valid_out}, {31'd0, v});
      chk({name, "_br"}, {31'd0, bus.branch_taken_out}, {31'd0, br});
   endtask

   initial begin
      int st;
      int seen;
      bus.valid_in = 1'b1; bus.opcode_in = 6'($urandom); bus.val_rs_in = $urandom;
      bus.val_rt_in = $urandom; bus.imm_in = $urandom; bus.rwd_in = 5'($urandom);
      @(posedge clk); #1;
      bus.opcode_in = 6'($urandom); bus.val_rs_in = $urandom; bus.val_rt_in = $urandom;
      @(posedge clk); #1;
      rst = 1'b0; bus.valid_in = 1'b0;
      expect_out("rst", 32'd0, 5'd0, 1'b0, 1'b0);
      chk("rst_rt", bus.val_rt_out, 32'd0);
      chk("rst_op", {26'd0, bus.opcode_out}, 32'd0);
      @(posedge clk); #1;
      expect_out("post_rst", 32'd0, 5'd0, 1'b0, 1'b0);
      chk("post_rst_stall", {31'd0, bus.stall_out}, 32'd0);

      issue(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'h2, 32'h0, 5'd5, st);
      expect_out("add", 32'h1, 5'd5, 1'b1, 1'b0);
      issue(1'b1, OP_LDW, 32'h100, 32'h0, 32'hFFFF_FFFC, 5'd6, st);
      expect_out("ldw", 32'hFC, 5'd6, 1'b1, 1'b0);
      issue(1'b1, OP_BEQ, 32'h55, 32'h55, 32'h0, 5'd0, st);
      expect_out("beq_eq", 32'h0, 5'd0, 1'b1, 1'b1);
      issue(1'b1, OP_BEQ, 32'h1, 32'h2, 32'h0, 5'd0, st);
      expect_out("beq_ne", 32'hFFFF_FFFF, 5'd0, 1'b1, 1'b0);
      issue(1'b1, OP_AND, 32'hF0F0, 32'hFF00, 32'h0, 5'd7, st);
      expect_out("and", 32'hF000, 5'd7, 1'b1, 1'b0);
      issue(1'b1, OP_JUMP, 32'h0, 32'h0, 32'h1234, 5'd0, st);
      expect_out("jump", 32'h1234, 5'd0, 1'b1, 1'b0);
      issue(1'b1, OP_SDW, 32'h40, 32'hDEAD, 32'h8, 5'd0, st);
      expect_out("sdw", 32'h48, 5'd0, 1'b1, 1'b0);
      chk("sdw_data", bus.val_rt_out, 32'hDEAD);
      issue(1'b1, 6'h3F, 32'h9, 32'h9, 32'h9, 5'd9, st);
      expect_out("nop", 32'h0, 5'd0, 1'b1, 1'b0);

      issue(1'b1, OP_MUL, 32'h7, 32'hFFFF_FFFD, 32'h0, 5'd12, st);
      chk("mul_stall_cycles", st, 32'd32);
      expect_out("mul", 32'hFFFF_FFEB, 5'd12, 1'b1, 1'b0);
      issue(1'b1, OP_ADD, 32'h1, 32'h1, 32'h0, 5'd3, st);
      expect_out("add_after_mul", 32'h2, 5'd3, 1'b1, 1'b0);
      issue(1'b1, OP_MUL, 32'h3, 32'h5, 32'h0, 5'd4, st);
      issue(1'b1, OP_MUL, 32'h6, 32'h6, 32'h0, 5'd8, st);
      chk("mul2_stall_cycles", st, 32'd32);
      expect_out("mul2", 32'd36, 5'd8, 1'b1, 1'b0);

      bus.valid_in = 1'b1; bus.opcode_in = OP_MUL; bus.val_rs_in = 32'hFFFF;
      bus.val_rt_in = 32'hFFFF; bus.rwd_in = 5'd11;
      @(posedge clk);
      repeat (10) @(posedge clk);
      #1; rst = 1'b1; bus.valid_in = 1'b0;
      @(posedge clk); #1; rst = 1'b0;
      expect_out("mul_abort", 32'h0, 5'd0, 1'b0, 1'b0);
      chk("mul_abort_stall", {31'd0, bus.stall_out}, 32'd0);
      seen = 0;
      repeat (35) begin
         @(negedge clk);
         if (bus.valid_out === 1'b1) seen++;
      end
      chk("mul_abort_no_result", seen, 32'd0);
      @(posedge clk); #1;
      issue(1'b1, OP_OR, 32'hF0, 32'h0F, 32'h0, 5'd2, st);
      expect_out("or", 32'hFF, 5'd2, 1'b1, 1'b0);

      for (int i = 0; i < 3; i++) begin
         issue(1'b0, OP_SUB, 32'h5, 32'h7, 32'h0, 5'd3, st);
         expect_out("sub_bubble", 32'h0, 5'd0, 1'b0, 1'b0);
         issue(1'b1, OP_SUB, 32'h5, 32'h7, 32'h0, 5'd3, st);
         expect_out("sub", 32'hFFFF_FFFE, 5'd3, 1'b1, 1'b0);
      end
      issue(1'b0, 6'd0, 32'h0, 32'h0, 32'h0, 5'd0, st);
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
      $fatal(1, "watchdog");
   end
endmodule
